decode_scoreboard: RTL and testbench

Register scoreboard and issue controller for the decode stage. It tracks which architectural registers have a write in flight and gates instruction issue from decode on RAW/WAW hazards, an in-flight limit and a drain request. It replaces the fixed EX/MEM destination comparison with per-register busy state, so variable-latency loads are handled correctly. It produces the IF stall and the registered EX bubble indicator.

---
 rtl/decode_scoreboard.sv | 153 +++++++++++++++
 tb/tb_decode_scoreboard.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write tracking and issue gating.
// Optional macro SB_BYPASS_EN lets a same-cycle writeback release the hazard on its register.
//
// state  | meaning
// IDLE   | no tracked writes outstanding
// ACTIVE | one or more tracked writes outstanding
// DRAIN  | issue blocked until every outstanding write has committed
module decode_scoreboard #(
    parameter  int NUM_REGS     = 32,
    parameter  int REG_IDX_SIZE = 5,
    parameter  int MAX_INFLIGHT = 4,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    issue_valid_i,
    input  logic [REG_IDX_SIZE-1:0] issue_rs1_i,
    input  logic [REG_IDX_SIZE-1:0] issue_rs2_i,
    input  logic                    issue_uses_rs1_i,
    input  logic                    issue_uses_rs2_i,
    input  logic                    issue_wr_i,
    input  logic [REG_IDX_SIZE-1:0] issue_rd_i,
    input  logic                    wb_valid_i,
    input  logic [REG_IDX_SIZE-1:0] wb_rd_i,
    input  logic                    flush_i,
    input  logic                    drain_req_i,
    output logic                    issue_ready_o,
    output logic                    stall_if_o,
    output logic                    stall_ex_o,
    output logic [NUM_REGS-1:0]     busy_o,
    output logic [CNT_W-1:0]        inflight_cnt_o,
    output logic                    full_o,
    output logic                    drain_done_o,
    output logic                    spurious_wb_o
);

`ifdef SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] eff_busy;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stall_ex_q;
    logic                spur_q, spur_d;

    logic rs1_haz, rs2_haz, waw_haz, hazard;
    logic issue_fire, track;
    logic wb_nz, wb_hit, wb_spur;

    // Bypass view: a register being written back this cycle no longer blocks issue.
    always_comb begin
        eff_busy = busy_q;
        if (BYPASS && wb_valid_i) begin
            eff_busy[wb_rd_i] = 1'b0;
        end
    end

    assign rs1_haz = issue_uses_rs1_i && (issue_rs1_i != '0) && eff_busy[issue_rs1_i];
    assign rs2_haz = issue_uses_rs2_i && (issue_rs2_i != '0) && eff_busy[issue_rs2_i];
    assign waw_haz = issue_wr_i       && (issue_rd_i  != '0) && eff_busy[issue_rd_i];
    assign hazard  = issue_valid_i && (rs1_haz || rs2_haz || waw_haz);

    assign full_o        = (cnt_q == CNT_W'(MAX_INFLIGHT));
    assign issue_ready_o = ~hazard & ~full_o & (state_q != ST_DRAIN) & ~drain_req_i & ~flush_i;
    assign stall_if_o    = issue_valid_i & ~issue_ready_o;

    assign issue_fire = issue_valid_i & issue_ready_o;
    assign track      = issue_fire & issue_wr_i & (issue_rd_i != '0);
    assign wb_nz      = wb_valid_i & (wb_rd_i != '0);
    assign wb_hit     = wb_nz &  busy_q[wb_rd_i];
    assign wb_spur    = wb_nz & ~busy_q[wb_rd_i];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (track) begin
            set_mask[issue_rd_i] = 1'b1;
        end
        if (wb_hit) begin
            clr_mask[wb_rd_i] = 1'b1;
        end

        // Set after clear so a bypassed same-register issue/writeback leaves the bit busy.
        busy_d  = (busy_q & ~clr_mask) | set_mask;
        cnt_d   = cnt_q + CNT_W'(track) - CNT_W'(wb_hit);
        spur_d  = spur_q | wb_spur;
        state_d = state_q;

        case (state_q)
            ST_IDLE: begin
                if (drain_req_i) begin
                    state_d = ST_DRAIN;
                end else if (track) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (drain_req_i) begin
                    state_d = ST_DRAIN;
                end else if (cnt_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            busy_d  = '0;
            cnt_d   = '0;
            spur_d  = spur_q;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= '0;
            cnt_q      <= '0;
            stall_ex_q <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            stall_ex_q <= stall_if_o;
            spur_q     <= spur_d;
        end
    end

    assign busy_o         = busy_q;
    assign inflight_cnt_o = cnt_q;
    assign stall_ex_o     = stall_ex_q;
    assign spurious_wb_o  = spur_q;
    assign drain_done_o   = (state_q == ST_DRAIN) && (cnt_q == '0);

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: set-based reference model plus directed literal checks.
module tb_decode_scoreboard;
    localparam int NR = 32;
    localparam int RW = 5;
    localparam int MI = 4;
    localparam int CW = $clog2(MI + 1);
`ifdef SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid, issue_uses_rs1, issue_uses_rs2, issue_wr;
    logic [RW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic          flush, drain_req;
    logic          issue_ready, stall_if, stall_ex, full, drain_done, spurious;
    logic [NR-1:0] busy;
    logic [CW-1:0] cnt;

    decode_scoreboard #(.NUM_REGS(NR), .REG_IDX_SIZE(RW), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid_i(issue_valid), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
        .issue_uses_rs1_i(issue_uses_rs1), .issue_uses_rs2_i(issue_uses_rs2),
        .issue_wr_i(issue_wr), .issue_rd_i(issue_rd),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .flush_i(flush), .drain_req_i(drain_req),
        .issue_ready_o(issue_ready), .stall_if_o(stall_if), .stall_ex_o(stall_ex),
        .busy_o(busy), .inflight_cnt_o(cnt), .full_o(full),
        .drain_done_o(drain_done), .spurious_wb_o(spurious)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Reference model: a set of pending registers, a draining flag, the sticky flag.
    bit mb[NR];
    bit m_drain, m_spur, m_prev_stall;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(mb[i]);
        return c;
    endfunction

    function automatic bit m_eff(int i);
        return mb[i] && !(BYP && wb_valid && int'(wb_rd) == i);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = issue_valid && ((issue_uses_rs1 && issue_rs1 != 0 && m_eff(int'(issue_rs1))) ||
                             (issue_uses_rs2 && issue_rs2 != 0 && m_eff(int'(issue_rs2))) ||
                             (issue_wr       && issue_rd  != 0 && m_eff(int'(issue_rd))));
        return !flush && !m_drain && !drain_req && (m_count() < MI) && !hz;
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] v = '0;
        for (int i = 0; i < NR; i++) v[i] = mb[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_update
        bit rdy, trk;
        int c;
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) mb[i] = 1'b0;
            m_drain = 1'b0;
            m_spur = 1'b0;
            m_prev_stall = 1'b0;
        end else begin
            rdy = m_ready();
            m_prev_stall = issue_valid && !rdy;
            if (flush) begin
                for (int i = 0; i < NR; i++) mb[i] = 1'b0;
                m_drain = 1'b0;
            end else begin
                c = m_count();
                trk = issue_valid && rdy && issue_wr && issue_rd != 0;
                if (wb_valid && wb_rd != 0) begin
                    if (mb[wb_rd]) mb[wb_rd] = 1'b0;
                    else m_spur = 1'b1;
                end
                if (trk) mb[issue_rd] = 1'b1;
                if (m_drain) begin
                    if (c == 0) m_drain = 1'b0;
                end else if (drain_req) begin
                    m_drain = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("issue_ready", issue_ready, m_ready());
            chk("stall_if", stall_if, issue_valid && !m_ready());
            chk("stall_ex", stall_ex, m_prev_stall);
            chk("busy", busy, m_busy());
            chk("inflight_cnt", cnt, m_count());
            chk("full", full, m_count() == MI);
            chk("drain_done", drain_done, m_drain && m_count() == 0);
            chk("spurious_wb", spurious, m_spur);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_wr = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
    endtask

    task automatic issue_wr_seq(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            idle();
            issue_valid = 1; issue_wr = 1; issue_rd = RW'(r);
            cyc();
        end
        idle();
    endtask

    task automatic wb_seq(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            idle();
            wb_valid = 1; wb_rd = RW'(r);
            cyc();
        end
        idle();
    endtask

    initial begin
        reset_n = 0;
        idle();
        repeat (2) cyc();
        reset_n = 1;
        check_en = 1;
        chk("reset_busy", busy, 0);
        chk("reset_cnt", cnt, 0);

        // RAW on x5 released by writeback
        issue_wr_seq(5, 5);
        chk("t1_busy5", busy, 32'h0000_0020);
        issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 5;
        #1 chk("t1_stall_if", stall_if, 1);
        cyc();
        chk("t1_stall_ex", stall_ex, 1);
        wb_valid = 1; wb_rd = 5;
        #1 chk("t1_ready_wb_cycle", issue_ready, BYP);
        cyc();
        wb_valid = 0;
        #1 chk("t1_ready_after", issue_ready, 1);
        chk("t1_busy_clear", busy, 0);
        cyc();
        idle();

        // In-flight limit
        issue_wr_seq(1, 4);
        chk("t2_cnt4", cnt, 4);
        chk("t2_full", full, 1);
        issue_valid = 1; issue_wr = 1; issue_rd = 6;
        #1 chk("t2_refused", issue_ready, 0);
        wb_valid = 1; wb_rd = 1;
        #1 chk("t2_refused_wb", issue_ready, 0);
        cyc();
        wb_valid = 0;
        #1 chk("t2_slot_free", issue_ready, 1);
        cyc();
        idle();
        chk("t2_cnt_after", cnt, 4);
        chk("t2_busy_after", busy, 32'h0000_005C);
        wb_seq(2, 4);
        wb_seq(6, 6);
        chk("t2_empty", cnt, 0);

        // x0 never tracked
        issue_valid = 1; issue_wr = 1; issue_rd = 0; issue_uses_rs1 = 1; issue_rs1 = 0;
        #1 chk("t3_no_stall", stall_if, 0);
        cyc();
        cyc();
        chk("t3_busy", busy, 0);
        chk("t3_cnt", cnt, 0);
        idle();

        // Drain
        issue_wr_seq(1, 3);
        drain_req = 1; issue_valid = 1; issue_wr = 1; issue_rd = 9;
        #1 chk("t4_ready_req", issue_ready, 0);
        cyc();
        drain_req = 0;
        #1 chk("t4_ready_drain", issue_ready, 0);
        for (int r = 1; r <= 3; r++) begin
            wb_valid = 1; wb_rd = RW'(r);
            cyc();
        end
        wb_valid = 0;
        #1 chk("t4_done", drain_done, 1);
        chk("t4_ready_done", issue_ready, 0);
        cyc();
        chk("t4_done_pulse", drain_done, 0);
        chk("t4_resume", issue_ready, 1);
        cyc();
        idle();
        chk("t4_busy9", busy, 32'h0000_0200);
        wb_seq(9, 9);

        // Flush beats simultaneous issue and writeback
        issue_wr_seq(1, 2);
        issue_valid = 1; issue_wr = 1; issue_rd = 3; wb_valid = 1; wb_rd = 1; flush = 1;
        cyc();
        idle();
        chk("t5_busy", busy, 0);
        chk("t5_cnt", cnt, 0);
        wb_valid = 1; wb_rd = 7;
        cyc();
        idle();
        chk("t5_spurious", spurious, 1);
        cyc();
        chk("t5_spurious_sticky", spurious, 1);

        // Reset while ACTIVE
        issue_wr_seq(4, 4);
        issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 4;
        reset_n = 0;
        cyc();
        chk("t6_busy", busy, 0);
        chk("t6_cnt", cnt, 0);
        chk("t6_stall_ex", stall_ex, 0);
        chk("t6_spurious", spurious, 0);
        chk("t6_drain_done", drain_done, 0);
        reset_n = 1;
        idle();
        cyc();

        // Randomized traffic on a small register window
        for (int n = 0; n < 3000; n++) begin
            reset_n        = ($urandom_range(0, 299) != 0);
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_uses_rs1 = 1'($urandom_range(0, 1));
            issue_uses_rs2 = 1'($urandom_range(0, 1));
            issue_wr       = ($urandom_range(0, 3) != 0);
            issue_rs1      = RW'($urandom_range(0, 7));
            issue_rs2      = RW'($urandom_range(0, 7));
            issue_rd       = RW'($urandom_range(0, 7));
            wb_valid       = ($urandom_range(0, 9) < 4);
            wb_rd          = RW'($urandom_range(0, 7));
            flush          = ($urandom_range(0, 59) == 0);
            drain_req      = ($urandom_range(0, 39) == 0);
            cyc();
        end
        reset_n = 1;
        idle();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
